multdiv_param: RTL and testbench
================================

# multdiv_param

Parametrised, iterative integer multiply/divide unit: the next generation of the processor's `multdiv` block. It adds selectable operand width, a signed/unsigned mode, a high-word output (product upper half or remainder), overflow detection and abort-on-restart. It sits beside the ALU in the execute stage, and the pipeline stalls on it until `data_resultRDY`.

## Interface
- `WIDTH`, default 32: operand and result width; must be even and ≥ 4.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `data_operandA`  in  WIDTH: multiplicand or dividend; sampled on the start edge only.
- `data_operandB`  in  WIDTH: multiplier or divisor; sampled on the start edge only.
- `ctrl_MULT`  in  1: one-cycle start pulse for a multiply.
- `ctrl_DIV`  in  1: one-cycle start pulse for a divide.
- `ctrl_SIGNED`  in  1: 1 = two's-complement operands, 0 = unsigned; sampled on the start edge.
- `data_result`  out  WIDTH: low product word, or quotient.
- `data_resultHI`  out  WIDTH: high product word, or remainder.
- `data_exception`  out  1: qualifies the current result; valid while `data_resultRDY` = 1.
- `data_resultRDY`  out  1: one-cycle pulse that marks a new result.

## Operation
- **States:** IDLE, MUL, DIV, FIX, DONE.
- **Start edge:** any rising edge with `ctrl_MULT` or `ctrl_DIV` high.
  - Latch operands and `ctrl_SIGNED`, clear the iteration counter, go to MUL or DIV.
  - If `ctrl_MULT` and `ctrl_DIV` are both high, MULT wins.
- **Signed mode:** convert operands to magnitudes at start; record the result signs.
- **MUL:** radix-2 shift-add, one bit per cycle, for WIDTH cycles. This builds the 2·WIDTH unsigned product.
- **DIV:** non-restoring division, one quotient bit per cycle, for WIDTH cycles, on a WIDTH+1-bit partial remainder.
- **FIX:** one cycle.
  - Division: restoring correction of the remainder.
  - Signed mode: negate results as required.
  - Register all outputs.
- **DONE:** `data_resultRDY` = 1 for this one cycle, then return to IDLE.
- **Output hold:** `data_result`, `data_resultHI` and `data_exception` hold their values until the next FIX.
- **Multiply results:**
  - `data_result` = product[WIDTH-1:0]; `data_resultHI` = product[2·WIDTH-1:WIDTH].
  - Exception (unsigned): `data_resultHI` ≠ 0.
  - Exception (signed): `data_resultHI` is not the sign-extension of `data_result[WIDTH-1]`.
- **Divide results:**
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Divisor = 0: result 0, resultHI 0, exception 1, with full latency (no early exit).
  - Signed MIN / −1: result = MIN (1 followed by WIDTH-1 zeros), resultHI 0, exception 1.
  - Otherwise exception 0.
- **Restart while busy:** a start edge in MUL, DIV, FIX or DONE aborts the current operation. The new operation restarts from cycle 0, and no RDY pulse is produced for the aborted one.

## Timing
- **Reset values:** `data_result` = 0, `data_resultHI` = 0, `data_exception` = 0, `data_resultRDY` = 0, state IDLE.
  - Reset takes effect immediately and asynchronously, including mid-operation.
  - Release is synchronised by the environment; no op starts until after the first edge with `reset_n` high.
- **Latency:** call the start edge edge 0.
  - Edges 1..WIDTH perform the iterations; edge WIDTH+1 is FIX.
  - `data_resultRDY` is high between edge WIDTH+1 and edge WIDTH+2, i.e. 33 edges after the start for WIDTH=32.
  - Latency is identical for MUL, DIV, all exception cases and both signed modes.
- **Throughput:** a new start is accepted on the edge that ends the DONE cycle, giving back-to-back ops every WIDTH+2 cycles.
- **Operand hold:** operands need not be held after the start edge.

## Structure
- **Shared package `multdiv_pkg`:**
  - State enum `md_state_t` {IDLE, MUL, DIV, FIX, DONE}.
  - Op enum `md_op_t` {OP_MUL, OP_DIV}.
  - Function `md_latency(width)` = width+2, used by the bench.
- **Sub-module `multdiv_addsub`:** a WIDTH+1-bit add/subtract with carry-out, shared by the MUL accumulate and DIV step paths.
- **Top level:** contains the FSM, counter, operand/accumulator registers and the sign/exception logic.

## Test plan (WIDTH=32)
- Unsigned DIV 7 / 3, one-cycle `ctrl_DIV` pulse at edge 0 → at edge 33: RDY = 1 for exactly one cycle, result 2, resultHI 1, exception 0.
- Signed MUL −7 × 3 → result 0xFFFFFFEB, resultHI 0xFFFFFFFF, exception 0.
- Signed MUL 0x7FFFFFFF × 2 → result 0xFFFFFFFE, exception 1.
- Unsigned MUL of the same operands → result 0xFFFFFFFE, resultHI 0, exception 0.
- DIV 5 / 0 → exception 1, result 0 at edge 33.
- Signed DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1.
- Start MUL 6 × 7, then pulse `ctrl_DIV` with 100 / 9 at edge 10 → no RDY at edge 33; RDY at edge 43 with result 11, resultHI 1.
- Assert `reset_n` low at edge 15 of an operation → all outputs 0 immediately; no RDY after release until a new start.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

    // Start edge to end of the RDY cycle, counted in clock edges.
    function automatic int md_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// WIDTH+1-bit adder/subtractor with carry-out, shared by the multiply
// accumulate and divide step paths.
module multdiv_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] op_a,
    input  logic [WIDTH:0] op_b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           cout
);

    logic [WIDTH:0] op_b_eff;

    assign op_b_eff    = sub ? ~op_b : op_b;
    assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b_eff} + {{(WIDTH + 1){1'b0}}, sub};

endmodule

// File: rtl/multdiv_param.sv
// Parametrised iterative multiply/divide: shift-add multiply, non-restoring
// divide, one bit per cycle, with signed mode, high word and overflow flag.
module multdiv_param
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_resultHI,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [2:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

    md_state_t        state_q, state_d;
    md_op_t           op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] wrk_q, wrk_d;    // multiplier / product low, or dividend / quotient
    logic [WIDTH:0]   acc_q, acc_d;    // product high, or signed partial remainder
    logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             sgn_q, sgn_d, div0_q, div0_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic             exc_q, exc_d, rdy_q, rdy_d;

    logic             start, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, rem_mag, quo_s, rem_s;
    logic [2*WIDTH-1:0] prod_mag, prod_s;
    logic [WIDTH:0]   as_a, as_b, as_sum;
    logic             as_sub, as_cout;

    multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .op_a (as_a),
        .op_b (as_b),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    always_comb begin
        start = ctrl_MULT | ctrl_DIV;
        a_neg = ctrl_SIGNED & data_operandA[WIDTH-1];
        b_neg = ctrl_SIGNED & data_operandB[WIDTH-1];
        a_mag = a_neg ? -data_operandA : data_operandA;
        b_mag = b_neg ? -data_operandB : data_operandB;

        // In FIX the adder restores a negative remainder by adding the divisor back.
        as_a   = acc_q;
        as_b   = {1'b0, dvs_q};
        as_sub = 1'b0;
        if (state_q == MUL) begin
            as_b = wrk_q[0] ? {1'b0, dvs_q} : '0;
        end else if (state_q == DIV) begin
            as_a   = {acc_q[WIDTH-1:0], wrk_q[WIDTH-1]};
            as_sub = ~acc_q[WIDTH];
        end

        prod_mag = {acc_q[WIDTH-1:0], wrk_q};
        prod_s   = neg_lo_q ? -prod_mag : prod_mag;
        rem_mag  = acc_q[WIDTH] ? as_sum[WIDTH-1:0] : acc_q[WIDTH-1:0];
        quo_s    = neg_lo_q ? -wrk_q : wrk_q;
        rem_s    = neg_hi_q ? -rem_mag : rem_mag;

        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        dvs_d    = dvs_q;
        wrk_d    = wrk_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        sgn_d    = sgn_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        res_d    = res_q;
        hi_d     = hi_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            MUL: begin
                acc_d = {as_cout, as_sum[WIDTH:1]};
                wrk_d = {as_sum[0], wrk_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            DIV: begin
                acc_d = as_sum;
                wrk_d = {wrk_q[WIDTH-2:0], ~as_sum[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                rdy_d   = 1'b1;
                if (op_q == OP_MUL) begin
                    res_d = prod_s[WIDTH-1:0];
                    hi_d  = prod_s[2*WIDTH-1:WIDTH];
                    exc_d = sgn_q ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                                  : (prod_s[2*WIDTH-1:WIDTH] != '0);
                end else if (div0_q) begin
                    res_d = '0;
                    hi_d  = '0;
                    exc_d = 1'b1;
                end else begin
                    res_d = quo_s;
                    hi_d  = rem_s;
                    exc_d = ovf_q;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // A start edge in any state aborts whatever is in flight.
        if (start) begin
            state_d  = ctrl_MULT ? MUL : DIV;
            op_d     = ctrl_MULT ? OP_MUL : OP_DIV;
            cnt_d    = '0;
            dvs_d    = ctrl_MULT ? a_mag : b_mag;
            wrk_d    = ctrl_MULT ? b_mag : a_mag;
            acc_d    = '0;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = ctrl_MULT ? (a_neg ^ b_neg) : a_neg;
            sgn_d    = ctrl_SIGNED;
            div0_d   = (data_operandB == '0);
            ovf_d    = ctrl_SIGNED && (data_operandA == MIN_VAL) && (data_operandB == '1);
            res_d    = res_q;
            hi_d     = hi_q;
            exc_d    = exc_q;
            rdy_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            dvs_q    <= '0;
            wrk_q    <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            sgn_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            res_q    <= '0;
            hi_q     <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            dvs_q    <= dvs_d;
            wrk_q    <= wrk_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            sgn_q    <= sgn_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_resultHI  = hi_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_param.sv
// Bench for multdiv_param: arithmetic reference model, per-cycle compare
// against an expected queue, directed cases plus randomized ops with aborts.
module tb_multdiv_param;
    import multdiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] data_operandA, data_operandB;
    logic         ctrl_MULT, ctrl_DIV, ctrl_SIGNED;
    logic [W-1:0] data_result, data_resultHI;
    logic         data_exception, data_resultRDY;
    logic [2:0]   dbg_state;

    multdiv_param #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_SIGNED    (ctrl_SIGNED),
        .data_result    (data_result),
        .data_resultHI  (data_resultHI),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard
    logic [W-1:0] exp_res_q[$];
    logic [W-1:0] exp_hi_q[$];
    logic         exp_exc_q[$];
    int           due_q[$];
    logic [W-1:0] hold_res = '0;
    logic [W-1:0] hold_hi  = '0;
    logic         hold_exc = 1'b0;
    bit           chk_en   = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_sb();
        exp_res_q.delete();
        exp_hi_q.delete();
        exp_exc_q.delete();
        due_q.delete();
    endtask

    // Returns {exception, high word, result} from plain integer arithmetic.
    function automatic logic [2*W:0] model(input bit div, input bit sg,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, q, r, lim;
        logic [63:0]  p;
        logic [W-1:0] res, hi;
        logic         exc;
        lim = longint'(1) << (W - 1);
        if (!div) begin
            if (sg) begin
                sa  = longint'($signed(a));
                sb  = longint'($signed(b));
                q   = sa * sb;
                p   = q;
                exc = (q >= lim) || (q < -lim);
            end else begin
                p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                exc = (p[2*W-1:W] != '0);
            end
            res = p[W-1:0];
            hi  = p[2*W-1:W];
        end else if (b == '0) begin
            res = '0;
            hi  = '0;
            exc = 1'b1;
        end else if (sg) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q   = sa / sb;
            r   = sa % sb;
            res = q[W-1:0];
            hi  = r[W-1:0];
            exc = (q >= lim);
        end else begin
            res = a / b;
            hi  = a % b;
            exc = 1'b0;
        end
        return {exc, hi, res};
    endfunction

    // compare process: RDY timing and held outputs, every cycle
    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_rdy;
            exp_rdy = (due_q.size() > 0) && (due_q[0] == cyc);
            check("rdy", W'(data_resultRDY), W'(exp_rdy));
            if (exp_rdy) begin
                hold_res = exp_res_q.pop_front();
                hold_hi  = exp_hi_q.pop_front();
                hold_exc = exp_exc_q.pop_front();
                void'(due_q.pop_front());
            end
            check("result", data_result, hold_res);
            check("resultHI", data_resultHI, hold_hi);
            check("exception", W'(data_exception), W'(hold_exc));
            if (due_q.size() > 0 && cyc > due_q[0]) begin
                n_tests++;
                n_fail++;
                $display("FAIL rdy_missing: no RDY at cycle %0d, expected at %0d", cyc, due_q[0]);
                void'(exp_res_q.pop_front());
                void'(exp_hi_q.pop_front());
                void'(exp_exc_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic start_op(input bit div, input bit sg, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit abort, input bit both);
        logic [2*W:0] r;
        @(posedge clock);
        #2;
        if (abort) clear_sb();
        data_operandA = a;
        data_operandB = b;
        ctrl_SIGNED   = sg;
        ctrl_MULT     = !div;
        ctrl_DIV      = div | both;
        r = model(div, sg, a, b);
        exp_res_q.push_back(r[W-1:0]);
        exp_hi_q.push_back(r[2*W-1:W]);
        exp_exc_q.push_back(r[2*W]);
        due_q.push_back(cyc + md_latency(W));
        @(posedge clock);
        #2;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        ctrl_SIGNED   = $urandom_range(0, 1) == 1;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (due_q.size() != 0 && i < 300) begin
            @(posedge clock);
            i++;
        end
        if (due_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: result still pending after %0d cycles", name, i);
            clear_sb();
        end
        @(posedge clock);
        #2;
    endtask

    task automatic check_lit(input string name, input logic [W-1:0] r,
                             input logic [W-1:0] h, input logic e);
        check({name, "_res"}, data_result, r);
        check({name, "_hi"}, data_resultHI, h);
        check({name, "_exc"}, W'(data_exception), W'(e));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return {1'b1, {(W - 1){1'b0}}};
            4:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic rand_op(input bit abort);
        bit div, sg, both;
        div  = $urandom_range(0, 1) == 1;
        sg   = $urandom_range(0, 1) == 1;
        both = !div && ($urandom_range(0, 9) == 0);
        start_op(div, sg, pick(), pick(), abort, both);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [2*W:0] m;
        int mode, tgt;
        reset_n       = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        ctrl_SIGNED   = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1 reset_n = 1'b0;
        #1;
        check_lit("reset", '0, '0, 1'b0);
        check("reset_rdy", W'(data_resultRDY), '0);
        check("reset_state", W'(dbg_state), W'(IDLE));

        // hand-computed pins of the reference model
        m = model(1'b1, 1'b0, 32'd7, 32'd3);
        check("pin_div_7_3", m[W-1:0], 32'd2);
        check("pin_div_7_3_hi", m[2*W-1:W], 32'd1);
        m = model(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3);
        check("pin_smul_lo", m[W-1:0], 32'hFFFF_FFEB);
        check("pin_smul_hi", m[2*W-1:W], 32'hFFFF_FFFF);
        m = model(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("pin_ovf_res", m[W-1:0], 32'h8000_0000);
        check("pin_ovf_exc", W'(m[2*W]), W'(1));
        m = model(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("pin_sdiv_rem", m[2*W-1:W], 32'hFFFF_FFFF);

        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // directed cases
        start_op(1, 0, 32'd7, 32'd3, 0, 0);
        wait_done("udiv");
        check_lit("udiv_7_3", 32'd2, 32'd1, 1'b0);
        start_op(0, 1, 32'hFFFF_FFF9, 32'd3, 0, 0);
        wait_done("smul");
        check_lit("smul_m7_3", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        start_op(0, 1, 32'h7FFF_FFFF, 32'd2, 0, 0);
        wait_done("smul_ovf");
        check_lit("smul_ovf", 32'hFFFF_FFFE, 32'd0, 1'b1);
        start_op(0, 0, 32'h7FFF_FFFF, 32'd2, 0, 0);
        wait_done("umul");
        check_lit("umul", 32'hFFFF_FFFE, 32'd0, 1'b0);
        start_op(1, 0, 32'd5, 32'd0, 0, 0);
        wait_done("div0");
        check_lit("div0", 32'd0, 32'd0, 1'b1);
        start_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        wait_done("sdiv_ovf");
        check_lit("sdiv_ovf", 32'h8000_0000, 32'd0, 1'b1);
        start_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        wait_done("sdiv");
        check_lit("sdiv_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

        // restart: MUL at edge 0, DIV at edge 10
        start_op(0, 0, 32'd6, 32'd7, 0, 0);
        repeat (8) @(posedge clock);
        start_op(1, 0, 32'd100, 32'd9, 1, 0);
        wait_done("restart");
        check_lit("restart", 32'd11, 32'd1, 1'b0);

        // back-to-back: second start on the edge that ends DONE
        start_op(0, 0, 32'd1234, 32'd5678, 0, 0);
        tgt = due_q[0];
        for (int i = 0; i < 100 && cyc < tgt - 1; i++) begin
            @(posedge clock);
            #1;
        end
        start_op(1, 0, 32'd1000, 32'd7, 0, 0);
        wait_done("b2b");
        check_lit("b2b", 32'd142, 32'd6, 1'b0);

        // randomized ops with occasional aborts and back-to-back starts
        for (int n = 0; n < 60; n++) begin
            mode = $urandom_range(0, 9);
            rand_op(0);
            if (mode < 2) begin
                repeat ($urandom_range(0, W - 1)) @(posedge clock);
                rand_op(1);
            end else if (mode == 2) begin
                tgt = due_q[0];
                for (int i = 0; i < 100 && cyc < tgt - 1; i++) begin
                    @(posedge clock);
                    #1;
                end
                rand_op(0);
            end
            wait_done("random");
        end

        // asynchronous reset mid-operation
        start_op(0, 0, 32'd6, 32'd7, 0, 0);
        wait_done("pre_reset");
        check_lit("pre_reset", 32'd42, 32'd0, 1'b0);
        start_op(1, 0, 32'd1000, 32'd3, 0, 0);
        repeat (14) @(posedge clock);
        #2;
        reset_n = 1'b0;
        clear_sb();
        hold_res = '0;
        hold_hi  = '0;
        hold_exc = 1'b0;
        #1;
        check_lit("async_reset", '0, '0, 1'b0);
        check("async_reset_rdy", W'(data_resultRDY), '0);
        check("async_reset_state", W'(dbg_state), W'(IDLE));
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (60) @(posedge clock);
        #2;
        check_lit("post_reset", '0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
